piso_serializer: RTL and testbench

Parameterized parallel-in/serial-out transmitter and the counterpart to the team's n-bit parallel capture register. It accepts an n-bit word through a valid/ready handshake and shifts it out one bit per clock, with a per-bit valid and an end-of-word marker. It sits between parallel datapath registers and any single-wire serial sink, such as a deserializer or an off-chip link driver.

---
 rtl/piso_serializer_if.sv | 25 ++
 rtl/piso_serializer.sv | 104 ++++++++++
 tb/tb_piso_serializer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Parallel-word handshake and serial output bundle for piso_serializer.
// Handshake: a word is accepted on a rising clk edge where load && ready;
// ready never depends on load, so a source may hold load high and wait.
interface piso_serializer_if #(
   parameter int n = 8
) ();
   logic         load;        // word-valid strobe from the source
   logic [n-1:0] in;          // parallel word, sampled only on accept
   logic         ready;       // serializer can accept a word this cycle
   logic         sout;        // serial data bit
   logic         sout_valid;  // sout carries a data bit
   logic         last;        // sout is the final bit of its word

   // Source side: drives the word, observes the serial stream.
   modport master (
      output load, in,
      input  ready, sout, sout_valid, last
   );

   // Serializer side.
   modport slave (
      input  load, in,
      output ready, sout, sout_valid, last
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out transmitter. Accepts an n-bit word over a
// load/ready handshake and shifts it out one bit per clock with a per-bit
// valid and an end-of-word marker. Back-to-back words leave no gap because
// ready is raised during the last-bit cycle.
module piso_serializer #(
   parameter int n         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   piso_serializer_if.slave   bus,
   output logic               state_dbg   // 1 while a word is being shifted
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [n-1:0]  sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sout_q, sout_d;
   logic          sout_valid_q, sout_valid_d;
   logic          last_q, last_d;

   logic          ready_int;
   logic          accept;
   logic [CW-1:0] cnt_next;

   // ready depends only on state and counter, never on load.
   assign ready_int = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
   assign accept    = bus.load && ready_int;
   assign cnt_next  = cnt_q + CW'(1);

   // Next-state logic: accept has priority, so a load during the last-bit
   // cycle reloads directly without passing through IDLE.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      cnt_d        = cnt_q;
      sout_d       = sout_q;
      sout_valid_d = sout_valid_q;
      last_d       = last_q;

      if (accept) begin
         state_d      = SHIFT;
         sr_d         = bus.in;
         cnt_d        = '0;
         sout_d       = MSB_FIRST ? bus.in[n-1] : bus.in[0];
         sout_valid_d = 1'b1;
         last_d       = 1'b0;        // n >= 2, so bit 0 is never the last
      end else if (state_q == SHIFT) begin
         if (cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            cnt_d        = '0;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
            last_d       = 1'b0;
         end else begin
            cnt_d  = cnt_next;
            last_d = (cnt_next == CNT_LAST);
            // The register keeps the bit on sout at its outgoing end, so the
            // next bit to show sits one position further in.
            if (MSB_FIRST) begin
               sout_d = sr_q[n-2];
               sr_d   = sr_q << 1;
            end else begin
               sout_d = sr_q[1];
               sr_d   = sr_q >> 1;
            end
         end
      end
   end

   // State and registered outputs; async reset drops any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         cnt_q        <= '0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         last_q       <= last_d;
      end
   end

   assign bus.ready      = ready_int;
   assign bus.sout       = sout_q;
   assign bus.sout_valid = sout_valid_q;
   assign bus.last       = last_q;
   assign state_dbg      = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (n=8 MSB-first, n=8 LSB-first,
// n=2 MSB-first). Drivers push hand-written expected bit sequences into a
// per-instance queue when a word is accepted; monitors pop on every valid bit.
module tb_piso_serializer;

   logic clk;
   logic rst_n;
   logic dbg_a, dbg_b, dbg_c;

   int n_vec = 0;
   int n_err = 0;

   // {bit, last} per expected serial bit
   logic [1:0] exp_a_q[$];
   logic [1:0] exp_b_q[$];
   logic [1:0] exp_c_q[$];

   int run_a = 0, max_run_a = 0;
   int run_c = 0, max_run_c = 0;

   piso_serializer_if #(.n(8)) if_a ();
   piso_serializer_if #(.n(8)) if_b ();
   piso_serializer_if #(.n(2)) if_c ();

   piso_serializer #(.n(8), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a), .state_dbg(dbg_a));
   piso_serializer #(.n(8), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b), .state_dbg(dbg_b));
   piso_serializer #(.n(2), .MSB_FIRST(1'b1)) u_c (
      .clk(clk), .rst_n(rst_n), .bus(if_c), .state_dbg(dbg_c));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_seq(input int which, input int w, input logic [7:0] seq);
      // seq[w-1] is the first bit expected on sout
      for (int i = w - 1; i >= 0; i--) begin
         if (which == 0) exp_a_q.push_back({seq[i], i == 0});
         else if (which == 1) exp_b_q.push_back({seq[i], i == 0});
         else exp_c_q.push_back({seq[i], i == 0});
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin : mon_a
      logic [1:0] e;
      if (rst_n) begin
         if (if_a.sout_valid) begin
            run_a++;
            if (run_a > max_run_a) max_run_a = run_a;
            if (exp_a_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL a_unexpected_bit: got sout=%0b, expected no valid bit at %0t", if_a.sout, $time);
            end else begin
               e = exp_a_q.pop_front();
               check("a_sout", 32'(if_a.sout), 32'(e[1]));
               check("a_last", 32'(if_a.last), 32'(e[0]));
            end
         end else begin
            run_a = 0;
            check("a_idle_outputs", 32'({if_a.sout, if_a.last}), 32'h0);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [1:0] e;
      if (rst_n) begin
         if (if_b.sout_valid) begin
            if (exp_b_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL b_unexpected_bit: got sout=%0b, expected no valid bit at %0t", if_b.sout, $time);
            end else begin
               e = exp_b_q.pop_front();
               check("b_sout", 32'(if_b.sout), 32'(e[1]));
               check("b_last", 32'(if_b.last), 32'(e[0]));
            end
         end else begin
            check("b_idle_outputs", 32'({if_b.sout, if_b.last}), 32'h0);
         end
      end
   end

   always @(negedge clk) begin : mon_c
      logic [1:0] e;
      if (rst_n) begin
         if (if_c.sout_valid) begin
            run_c++;
            if (run_c > max_run_c) max_run_c = run_c;
            if (exp_c_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL c_unexpected_bit: got sout=%0b, expected no valid bit at %0t", if_c.sout, $time);
            end else begin
               e = exp_c_q.pop_front();
               check("c_sout", 32'(if_c.sout), 32'(e[1]));
               check("c_last", 32'(if_c.last), 32'(e[0]));
            end
         end else begin
            run_c = 0;
            check("c_idle_outputs", 32'({if_c.sout, if_c.last}), 32'h0);
         end
      end
   end

   // ---------------- drivers ----------------
   // Raise load with the word, wait (bounded) for ready, let the edge accept.
   // Called and returning at posedge+1; load is left high for the caller.
   task automatic send_a(input logic [7:0] w, input logic [7:0] seq);
      int t = 0;
      if_a.load = 1'b1;
      if_a.in   = w;
      while (!if_a.ready && t < 40) begin @(posedge clk); #1; t++; end
      if (!if_a.ready) begin
         n_vec++; n_err++;
         $display("FAIL a_ready_timeout: got ready=0, expected ready=1 within 40 cycles");
      end else begin
         @(posedge clk);
         push_seq(0, 8, seq);
         #1;
      end
   endtask

   task automatic send_b(input logic [7:0] w, input logic [7:0] seq);
      int t = 0;
      if_b.load = 1'b1;
      if_b.in   = w;
      while (!if_b.ready && t < 40) begin @(posedge clk); #1; t++; end
      if (!if_b.ready) begin
         n_vec++; n_err++;
         $display("FAIL b_ready_timeout: got ready=0, expected ready=1 within 40 cycles");
      end else begin
         @(posedge clk);
         push_seq(1, 8, seq);
         #1;
      end
   endtask

   task automatic send_c(input logic [1:0] w, input logic [1:0] seq);
      int t = 0;
      logic [7:0] s8;
      s8 = {6'b0, seq};
      if_c.load = 1'b1;
      if_c.in   = w;
      while (!if_c.ready && t < 40) begin @(posedge clk); #1; t++; end
      if (!if_c.ready) begin
         n_vec++; n_err++;
         $display("FAIL c_ready_timeout: got ready=0, expected ready=1 within 40 cycles");
      end else begin
         @(posedge clk);
         push_seq(2, 2, s8);
         #1;
      end
   endtask

   task automatic wait_idle_a();
      int t = 0;
      while ((exp_a_q.size() != 0 || if_a.sout_valid) && t < 60) begin @(posedge clk); #1; t++; end
      if (t >= 60) begin
         n_vec++; n_err++;
         $display("FAIL a_idle_timeout: got %0d bits pending, expected 0", exp_a_q.size());
      end
   endtask

   task automatic wait_idle_b();
      int t = 0;
      while ((exp_b_q.size() != 0 || if_b.sout_valid) && t < 60) begin @(posedge clk); #1; t++; end
      if (t >= 60) begin
         n_vec++; n_err++;
         $display("FAIL b_idle_timeout: got %0d bits pending, expected 0", exp_b_q.size());
      end
   endtask

   task automatic wait_idle_c();
      int t = 0;
      while ((exp_c_q.size() != 0 || if_c.sout_valid) && t < 60) begin @(posedge clk); #1; t++; end
      if (t >= 60) begin
         n_vec++; n_err++;
         $display("FAIL c_idle_timeout: got %0d bits pending, expected 0", exp_c_q.size());
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n     = 1'b0;
      if_a.load = 1'b1;       // load held during reset must not be accepted
      if_a.in   = 8'hFF;
      if_b.load = 1'b0;
      if_b.in   = 8'h00;
      if_c.load = 1'b0;
      if_c.in   = 2'b00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_outputs", 32'({if_a.sout, if_a.sout_valid, if_a.last}), 32'h0);
      check("rst_a_ready", 32'(if_a.ready), 32'h1);
      check("rst_a_state", 32'(dbg_a), 32'h0);
      check("rst_b_outputs", 32'({if_b.sout, if_b.sout_valid, if_b.last}), 32'h0);
      check("rst_b_ready", 32'(if_b.ready), 32'h1);
      check("rst_c_outputs", 32'({if_c.sout, if_c.sout_valid, if_c.last}), 32'h0);
      check("rst_c_ready", 32'(if_c.ready), 32'h1);
      @(negedge clk);
      if_a.load = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_a_valid", 32'(if_a.sout_valid), 32'h0);
      check("post_rst_a_state", 32'(dbg_a), 32'h0);

      // MSB-first 0x1E
      check("t1_ready_idle", 32'(if_a.ready), 32'h1);
      send_a(8'h1E, 8'b0001_1110);
      if_a.load = 1'b0;
      check("t1_ready_busy", 32'(if_a.ready), 32'h0);
      wait_idle_a();
      check("t1_valid_after", 32'(if_a.sout_valid), 32'h0);
      check("t1_ready_after", 32'(if_a.ready), 32'h1);

      // LSB-first 0x1E
      send_b(8'h1E, 8'b0111_1000);
      if_b.load = 1'b0;
      wait_idle_b();
      check("t2_ready_after", 32'(if_b.ready), 32'h1);

      // Back-to-back 0xFF then 0x00: 16 contiguous valid bits
      max_run_a = 0;
      send_a(8'hFF, 8'b1111_1111);
      send_a(8'h00, 8'b0000_0000);
      if_a.load = 1'b0;
      wait_idle_a();
      check("t3_contiguous_bits", 32'(max_run_a), 32'd16);

      // Busy rejection: 0xF0 pulsed on the 3rd bit cycle is dropped
      send_a(8'h0F, 8'b0000_1111);
      if_a.load = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t4_ready_bit3", 32'(if_a.ready), 32'h0);
      if_a.load = 1'b1;
      if_a.in   = 8'hF0;
      @(posedge clk); #1;
      if_a.load = 1'b0;
      wait_idle_a();
      repeat (4) @(posedge clk);
      #1;
      check("t4_ready_after", 32'(if_a.ready), 32'h1);
      check("t4_state_after", 32'(dbg_a), 32'h0);

      // Reset mid-word: 0xAA cut after its 4th bit
      send_a(8'hAA, 8'b1010_1010);
      if_a.load = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_outputs", 32'({if_a.sout, if_a.sout_valid, if_a.last}), 32'h0);
      check("t5_rst_ready", 32'(if_a.ready), 32'h1);
      check("t5_bits_dropped", 32'(exp_a_q.size()), 32'd4);
      exp_a_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_a(8'h81, 8'b1000_0001);
      if_a.load = 1'b0;
      wait_idle_a();

      // n=2 back-to-back 2'b10, ready every other cycle
      max_run_c = 0;
      send_c(2'b10, 2'b10);
      check("t6_ready_bit1_w1", 32'(if_c.ready), 32'h0);
      send_c(2'b10, 2'b10);
      if_c.load = 1'b0;
      check("t6_ready_bit1_w2", 32'(if_c.ready), 32'h0);
      @(posedge clk); #1;
      check("t6_ready_bit2_w2", 32'(if_c.ready), 32'h1);
      check("t6_last_bit2_w2", 32'(if_c.last), 32'h1);
      wait_idle_c();
      check("t6_contiguous_bits", 32'(max_run_c), 32'd4);

      repeat (2) @(posedge clk);
      #1;
      check("end_queue_a", 32'(exp_a_q.size()), 32'd0);
      check("end_queue_b", 32'(exp_b_q.size()), 32'd0);
      check("end_queue_c", 32'(exp_c_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
